// File: rtl/pmt_pulse_conditioner.sv
// PMT discriminator front end: synchronise, width-qualify, dead-time and guard-blank
// pulses, emitting one phase-tagged strobe per accepted pulse plus saturating statistics.
module pmt_pulse_conditioner #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MIN_WIDTH    = 2,
  parameter int unsigned DEAD_TIME    = 10,
  parameter int unsigned GUARD_CYCLES = 25,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clock_50_mhz,
  input  logic                 reset_n,
  input  logic                 PMT_in,
  input  logic                 light_source_flag,
  input  logic                 enable,
  input  logic                 clear,
  output logic                 event_valid,
  output logic                 event_phase,
  output logic [CNT_WIDTH-1:0] accepted_count,
  output logic [CNT_WIDTH-1:0] rejected_width_count,
  output logic [CNT_WIDTH-1:0] rejected_dead_count,
  output logic [CNT_WIDTH-1:0] rejected_guard_count
);

  localparam int unsigned WW = $clog2(MIN_WIDTH + 1);
  localparam int unsigned DW = $clog2(DEAD_TIME + 1);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  // Counter slots
  localparam int unsigned C_ACC   = 0;
  localparam int unsigned C_WIDTH = 1;
  localparam int unsigned C_DEAD  = 2;
  localparam int unsigned C_GUARD = 3;

  typedef enum logic [1:0] {IDLE, QUALIFY, DEAD} state_t;

  logic [SYNC_STAGES-1:0]     r_sync;
  logic                       r_s_d;
  logic                       r_flag_d;
  logic [GW-1:0]              r_guard_timer;
  state_t                     r_state;
  logic [WW-1:0]              r_width_cnt;
  logic [DW-1:0]              r_dead_cnt;
  logic                       r_phase_lat;
  logic                       r_guard_lat;
  logic [3:0][CNT_WIDTH-1:0]  r_cnt;

  logic                       w_s;
  logic                       w_rise;
  logic                       w_guard_active;
  logic                       w_last;
  logic [3:0]                 w_inc;

  assign w_s            = r_sync[SYNC_STAGES-1];
  assign w_rise         = w_s & ~r_s_d;
  assign w_guard_active = (light_source_flag ^ r_flag_d) | (r_guard_timer != '0);
  assign w_last         = (32'(r_width_cnt) + 32'd1) == MIN_WIDTH;

  // Synchroniser, edge register and modulation guard timer
  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync        <= '0;
      r_s_d         <= 1'b0;
      r_flag_d      <= 1'b0;
      r_guard_timer <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], PMT_in};
      r_s_d    <= w_s;
      r_flag_d <= light_source_flag;
      if (light_source_flag != r_flag_d) begin
        r_guard_timer <= GW'(GUARD_CYCLES);
      end else if (r_guard_timer != '0) begin
        r_guard_timer <= r_guard_timer - 1'b1;
      end
    end
  end

  // Statistic increment strobes decoded from the current FSM decision
  always_comb begin
    w_inc = '0;
    case (r_state)
      QUALIFY: begin
        if (enable && !w_s) begin
          w_inc[C_WIDTH] = 1'b1;
        end
        if (enable && w_s && w_last) begin
          if (r_guard_lat) w_inc[C_GUARD] = 1'b1;
          else             w_inc[C_ACC]   = 1'b1;
        end
      end
      DEAD:    w_inc[C_DEAD] = w_rise;
      default: w_inc = '0;
    endcase
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_width_cnt <= '0;
      r_dead_cnt  <= '0;
      r_phase_lat <= 1'b0;
      r_guard_lat <= 1'b0;
      event_valid <= 1'b0;
      event_phase <= 1'b0;
    end else begin
      event_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise && enable) begin
            r_state     <= QUALIFY;
            r_width_cnt <= WW'(1);
            r_phase_lat <= light_source_flag;
            r_guard_lat <= w_guard_active;
          end
        end
        QUALIFY: begin
          if (!enable || !w_s) begin
            r_state <= IDLE;
          end else if (!w_last) begin
            r_width_cnt <= r_width_cnt + 1'b1;
          end else begin
            // Guard-blanked pulses still consume a dead-time window
            r_state    <= DEAD;
            r_dead_cnt <= DW'(DEAD_TIME);
            if (!r_guard_lat) begin
              event_valid <= 1'b1;
              event_phase <= r_phase_lat;
            end
          end
        end
        DEAD: begin
          if (r_dead_cnt == DW'(1)) r_state <= IDLE;
          else                      r_dead_cnt <= r_dead_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign accepted_count       = r_cnt[C_ACC];
  assign rejected_width_count = r_cnt[C_WIDTH];
  assign rejected_dead_count  = r_cnt[C_DEAD];
  assign rejected_guard_count = r_cnt[C_GUARD];

endmodule
